// File: rtl/round_buffer_reader_pkg.sv
// Shared defaults and helpers for the circular sample buffer read side.
// Holds the parameter defaults, the level-width constant, the skid occupancy
// state encoding and the read-pointer wrap helper.
package round_buffer_reader_pkg;

  localparam int BUFFER_WIDTH_DEF     = 4;
  localparam int BUFFER_SIZE_DEF      = 16;
  localparam int DATA_WIDTH_DEF       = 16;
  localparam int LEVEL_WIDTH_DEF      = BUFFER_WIDTH_DEF + 1;
  localparam int ALMOST_EMPTY_THR_DEF = 2;

  // Occupancy of the 2-entry output skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // Advance a read address around a ring of 'size' entries.
  // The size need not be a power of two, so the wrap is explicit.
  function automatic int next_rd_addr(input int addr, input int size);
    return (addr == size - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/round_rd_skid.sv
// Purpose: 2-entry in-order valid/ready skid buffer (main + spare) for RAM read data.
// Latency: a word pushed on edge N is presented on out_vld/out_dat in cycle N+1.
// Backpressure: holds up to 2 words; the caller must not push when full and not consuming.
// Ports: clk/aclr/clk_en - clock, async active-high reset, global enable
//        push_dat/push_vld - returning RAM word; out_dat/out_vld/out_rdy - stream side
//        count - number of words held (0..2)
module round_rd_skid
  import round_buffer_reader_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 clk_en,
  input  logic [DataWidth-1:0] push_dat,
  input  logic                 push_vld,
  input  logic                 out_rdy,
  output logic [DataWidth-1:0] out_dat,
  output logic                 out_vld,
  output logic [1:0]           count
);

  skid_state_e          state_q, state_d;
  logic [DataWidth-1:0] main_q, main_d;
  logic [DataWidth-1:0] spare_q, spare_d;
  logic                 push;
  logic                 consume;

  // Nothing moves while the engine is globally stalled.
  assign push    = clk_en && push_vld;
  assign consume = clk_en && out_vld && out_rdy;

  // State register
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SKID_EMPTY: if (push) state_d = SKID_ONE;
      SKID_ONE: begin
        if (push && !consume)      state_d = SKID_TWO;
        else if (!push && consume) state_d = SKID_EMPTY;
      end
      SKID_TWO: if (consume && !push) state_d = SKID_ONE;
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    out_vld = 1'b0;
    count   = 2'd0;
    case (state_q)
      SKID_ONE: begin
        out_vld = 1'b1;
        count   = 2'd1;
      end
      SKID_TWO: begin
        out_vld = 1'b1;
        count   = 2'd2;
      end
      default: begin
        out_vld = 1'b0;
        count   = 2'd0;
      end
    endcase
  end

  // Data steering: an arriving word lands in main when main is free or
  // leaving this cycle, otherwise in spare. Spare moves up on consume.
  always_comb begin
    main_d  = main_q;
    spare_d = spare_q;
    case (state_q)
      SKID_EMPTY: if (push) main_d = push_dat;
      SKID_ONE: begin
        if (consume) begin
          if (push) main_d = push_dat;
        end else if (push) begin
          spare_d = push_dat;
        end
      end
      SKID_TWO: begin
        if (consume) begin
          main_d = spare_q;
          if (push) spare_d = push_dat;
        end
      end
      default: begin
        main_d  = main_q;
        spare_d = spare_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      main_q  <= '0;
      spare_q <= '0;
    end else begin
      main_q  <= main_d;
      spare_q <= spare_d;
    end
  end

  assign out_dat = main_q;

endmodule

// File: rtl/round_buffer_reader.sv
// Purpose: read-side controller of the circular sample buffer; owns R_Addr, derives Empty, issues Pop, streams words out.
// Latency: Pop in cycle N -> RAM data captured end of N+1 -> Out_Valid in N+2 at the earliest; 1 word/cycle sustained.
// Backpressure: at most 2 words in flight + held; Pop stalls once those slots are taken and the head is not being accepted.
// Ports: clk, aclr (async active-high), clk_en (global enable, freezes all state)
//        W_Addr/Round from the writer and wrap tracker; R_Addr/Pop to RAM and tracker; Mem_RData from RAM
//        Empty status; Out_Data/Out_Valid/Out_Ready downstream stream
// Optional: RD_LEVEL_EN adds registered Level and Almost_Empty outputs and the AlmostEmptyThr parameter.
module round_buffer_reader
  import round_buffer_reader_pkg::*;
#(
  parameter int BufferWidth = BUFFER_WIDTH_DEF,
  parameter int BufferSize  = BUFFER_SIZE_DEF,
  parameter int DataWidth   = DATA_WIDTH_DEF
`ifdef RD_LEVEL_EN
  , parameter int AlmostEmptyThr = ALMOST_EMPTY_THR_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   clk_en,
  input  logic [BufferWidth-1:0] W_Addr,
  input  logic                   Round,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Pop,
  input  logic [DataWidth-1:0]   Mem_RData,
  output logic                   Empty,
  output logic [DataWidth-1:0]   Out_Data,
  output logic                   Out_Valid,
  input  logic                   Out_Ready
`ifdef RD_LEVEL_EN
  , output logic [BufferWidth:0] Level,
  output logic                   Almost_Empty
`endif
);

  localparam int LevelWidth = BufferWidth + 1;

  logic [BufferWidth-1:0] r_addr_q, r_addr_d;
  logic                   inflight_q, inflight_d;
  logic                   empty;
  logic                   pop;
  logic [1:0]             skid_cnt;
  logic [1:0]             slots;
  logic                   skid_vld;

  // Pointers equal means empty unless the writer is a full lap ahead.
  assign empty = !Round && (W_Addr == r_addr_q);

  // A slot is either a read in flight from the RAM or a word held in the skid.
  // Two slots cover the RAM latency, so a third pop is only allowed when the
  // head word leaves this very cycle.
  assign slots = {1'b0, inflight_q} + skid_cnt;

  always_comb begin
    pop = 1'b0;
    if (clk_en && !empty) begin
      pop = (slots < 2'd2) || ((slots == 2'd2) && skid_vld && Out_Ready);
    end
  end

  always_comb begin
    r_addr_d   = r_addr_q;
    inflight_d = inflight_q;
    if (pop) begin
      r_addr_d = BufferWidth'(next_rd_addr(int'(r_addr_q), BufferSize));
    end
    // The in-flight flag tracks the RAM's registered read, which is gated by
    // the same enable; a stalled read completes once clk_en returns.
    if (clk_en) begin
      inflight_d = pop;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_addr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      r_addr_q   <= r_addr_d;
      inflight_q <= inflight_d;
    end
  end

  round_rd_skid #(
    .DataWidth(DataWidth)
  ) u_skid (
    .clk      (clk),
    .aclr     (aclr),
    .clk_en   (clk_en),
    .push_dat (Mem_RData),
    .push_vld (inflight_q),
    .out_rdy  (Out_Ready),
    .out_dat  (Out_Data),
    .out_vld  (skid_vld),
    .count    (skid_cnt)
  );

  assign R_Addr    = r_addr_q;
  assign Pop       = pop;
  assign Empty     = empty;
  assign Out_Valid = skid_vld;

`ifdef RD_LEVEL_EN
  logic                  full;
  logic [LevelWidth-1:0] level_q, level_d;
  logic                  almost_empty_q, almost_empty_d;

  assign full = Round && (W_Addr == r_addr_q);

  always_comb begin
    level_d        = level_q;
    almost_empty_d = almost_empty_q;
    if (clk_en) begin
      if (full) begin
        level_d = LevelWidth'(BufferSize);
      end else if (Round) begin
        level_d = LevelWidth'(BufferSize) - {1'b0, r_addr_q} + {1'b0, W_Addr};
      end else begin
        level_d = {1'b0, W_Addr} - {1'b0, r_addr_q};
      end
      almost_empty_d = (level_d <= LevelWidth'(AlmostEmptyThr));
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      level_q        <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      level_q        <= level_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign Level        = level_q;
  assign Almost_Empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_round_buffer_reader.sv
module tb_round_buffer_reader;

  localparam int BW = 4;
  localparam int BS = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          aclr;
  logic          clk_en;
  logic [BW-1:0] W_Addr;
  logic          Round;
  logic [BW-1:0] R_Addr;
  logic          Pop;
  logic [DW-1:0] Mem_RData;
  logic          Empty;
  logic [DW-1:0] Out_Data;
  logic          Out_Valid;
  logic          Out_Ready;
`ifdef RD_LEVEL_EN
  logic [BW:0]   Level;
  logic          Almost_Empty;
`endif

  always #5 clk = ~clk;

  round_buffer_reader #(
    .BufferWidth(BW),
    .BufferSize (BS),
    .DataWidth  (DW)
  ) dut (
    .clk       (clk),
    .aclr      (aclr),
    .clk_en    (clk_en),
    .W_Addr    (W_Addr),
    .Round     (Round),
    .R_Addr    (R_Addr),
    .Pop       (Pop),
    .Mem_RData (Mem_RData),
    .Empty     (Empty),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready)
`ifdef RD_LEVEL_EN
    , .Level       (Level),
    .Almost_Empty (Almost_Empty)
`endif
  );

  // Environment model: RAM contents, writer pointer, wrap tracker, and the
  // ordered list of words written but not yet delivered downstream.
  logic [DW-1:0] mem [0:BS-1];
  int            w_ptr;
  bit            rnd;
  logic [DW-1:0] exp_q [$];
  int            written;
  int            popped;
  int            lvl_exp;
  int            n_cmp;
  int            n_err;

  task automatic drive_writer();
    W_Addr = w_ptr[BW-1:0];
    Round  = rnd;
  endtask

  task automatic write_word();
    logic [31:0] r;
    r = $urandom();
    mem[w_ptr] = r[DW-1:0];
    exp_q.push_back(r[DW-1:0]);
    written++;
    if (w_ptr == BS - 1) begin
      w_ptr = 0;
      rnd   = ~rnd;
    end else begin
      w_ptr = w_ptr + 1;
    end
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      if (written - popped < BS) write_word();
    end
    drive_writer();
  endtask

  task automatic model_reset();
    w_ptr     = 0;
    rnd       = 1'b0;
    exp_q.delete();
    written   = 0;
    popped    = 0;
    lvl_exp   = 0;
    Mem_RData = '0;
    drive_writer();
  endtask

  task automatic do_reset();
    @(negedge clk);
    aclr      = 1'b1;
    clk_en    = 1'b0;
    Out_Ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 aclr = 1'b0;
  endtask

  // One clock cycle: apply enables, check the DUT at the falling edge against
  // the model, then advance the model across the rising edge.
  task automatic cycle(input bit wr_req, input bit rdy, input bit en,
                       output bit pop_o, output int ra_o, output bit hs_o,
                       output bit ov_o, output logic [DW-1:0] od_o);
    int cnt;
    bit do_wr;
    clk_en    = en;
    Out_Ready = rdy;
    @(negedge clk);
    pop_o = Pop;
    ra_o  = int'(R_Addr);
    ov_o  = Out_Valid;
    od_o  = Out_Data;
    hs_o  = Out_Valid && rdy && en;
    cnt   = written - popped;

    n_cmp++;
    if (Empty !== (cnt == 0)) begin
      n_err++;
      $display("FAIL empty: got %0b want %0b (unpopped=%0d)", Empty, cnt == 0, cnt);
    end
    n_cmp++;
    if (ra_o !== popped % BS) begin
      n_err++;
      $display("FAIL r_addr: got %0d want %0d", ra_o, popped % BS);
    end
    if (pop_o) begin
      n_cmp++;
      if (!en || cnt == 0) begin
        n_err++;
        $display("FAIL pop_illegal: got Pop=1 want 0 (en=%0b unpopped=%0d)", en, cnt);
      end
    end
    if (hs_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL stream_extra: got word %h want none", od_o);
      end else begin
        if (od_o !== exp_q[0]) begin
          n_err++;
          $display("FAIL stream_data: got %h want %h", od_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
`ifdef RD_LEVEL_EN
    n_cmp++;
    if (int'(Level) !== lvl_exp || Almost_Empty !== (lvl_exp <= 2)) begin
      n_err++;
      $display("FAIL level: got %0d/%0b want %0d/%0b", Level, Almost_Empty, lvl_exp, lvl_exp <= 2);
    end
`endif
    do_wr = wr_req && en && (cnt < BS);

    @(posedge clk);
    #1;
    if (en) lvl_exp = cnt;
    if (en && pop_o) begin
      Mem_RData = mem[ra_o % BS];
      popped++;
      if (ra_o == BS - 1) rnd = ~rnd;
    end
    if (do_wr) write_word();
    drive_writer();
  endtask

  task automatic test_reset();
    bit pop_o, hs_o, ov_o;
    int ra_o;
    logic [DW-1:0] od_o;
    do_reset();
    n_cmp++;
    if (Out_Valid !== 1'b0 || Out_Data !== '0 || R_Addr !== '0 || Pop !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got V=%0b D=%h R=%0d P=%0b want 0/0/0/0", Out_Valid, Out_Data, R_Addr, Pop);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
      n_cmp++;
      if (pop_o !== 1'b0 || ov_o !== 1'b0) begin
        n_err++;
        $display("FAIL idle: got Pop=%0b Valid=%0b want 0/0 at cycle %0d", pop_o, ov_o, i);
      end
    end
  endtask

  task automatic test_fill5();
    bit pop_o, hs_o, ov_o;
    int ra_o;
    logic [DW-1:0] od_o;
    logic [11:0] pop_mask, ov_mask;
    do_reset();
    preload(5);
    pop_mask = '0;
    ov_mask  = '0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
      pop_mask[i] = pop_o;
      ov_mask[i]  = ov_o;
    end
    n_cmp++;
    if (pop_mask !== 12'b0000_0001_1111) begin
      n_err++;
      $display("FAIL fill5_pops: got %b want %b", pop_mask, 12'b0000_0001_1111);
    end
    n_cmp++;
    if (ov_mask !== 12'b0000_0111_1100) begin
      n_err++;
      $display("FAIL fill5_valid: got %b want %b", ov_mask, 12'b0000_0111_1100);
    end
    n_cmp++;
    if (exp_q.size() != 0 || R_Addr !== 4'd5 || Empty !== 1'b1) begin
      n_err++;
      $display("FAIL fill5_end: got left=%0d R=%0d E=%0b want 0/5/1", exp_q.size(), R_Addr, Empty);
    end
  endtask

  task automatic test_wrap();
    bit pop_o, hs_o, ov_o;
    int ra_o;
    logic [DW-1:0] od_o;
    int addrs [$];
    do_reset();
    preload(14);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
    end
    preload(4);
    n_cmp++;
    if (R_Addr !== 4'd14 || W_Addr !== 4'd2 || Round !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_setup: got R=%0d W=%0d Round=%0b want 14/2/1", R_Addr, W_Addr, Round);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
      if (pop_o) addrs.push_back(ra_o);
    end
    n_cmp++;
    if (addrs.size() != 4 || addrs[0] != 14 || addrs[1] != 15 || addrs[2] != 0 || addrs[3] != 1) begin
      n_err++;
      $display("FAIL wrap_addrs: got %0d pops %p want 14,15,0,1", addrs.size(), addrs);
    end
    n_cmp++;
    if (Empty !== 1'b1 || R_Addr !== 4'd2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_end: got E=%0b R=%0d left=%0d want 1/2/0", Empty, R_Addr, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit pop_o, hs_o, ov_o;
    int ra_o;
    logic [DW-1:0] od_o;
    int npop;
    logic [19:0] hs_mask;
    do_reset();
    preload(8);
    npop = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
      if (pop_o) npop++;
    end
    n_cmp++;
    if (npop != 2) begin
      n_err++;
      $display("FAIL bp_pops: got %0d want 2", npop);
    end
    n_cmp++;
    if (ov_o !== 1'b1 || od_o !== exp_q[0]) begin
      n_err++;
      $display("FAIL bp_hold: got V=%0b D=%h want 1/%h", ov_o, od_o, exp_q[0]);
    end
    hs_mask = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
      hs_mask[i] = hs_o;
    end
    n_cmp++;
    if (hs_mask !== 20'h000FF || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_release: got %b left=%0d want %b/0", hs_mask, exp_q.size(), 20'h000FF);
    end
  endtask

  task automatic test_clk_en();
    bit pop_o, hs_o, ov_o;
    int ra_o;
    logic [DW-1:0] od_o;
    int nhs;
    do_reset();
    preload(6);
    cycle(1'b0, 1'b0, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, pop_o, ra_o, hs_o, ov_o, od_o);
      n_cmp++;
      if (ov_o !== 1'b0 || pop_o !== 1'b0) begin
        n_err++;
        $display("FAIL stall: got V=%0b P=%0b want 0/0", ov_o, pop_o);
      end
    end
    nhs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
      if (hs_o) nhs++;
    end
    n_cmp++;
    if (nhs != 6 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_drain: got %0d words left=%0d want 6/0", nhs, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit pop_o, hs_o, ov_o;
    int ra_o;
    logic [DW-1:0] od_o;
    int delivered;
    int cyc;
    do_reset();
    delivered = 0;
    cyc = 0;
    while (delivered < 1000 && cyc < 20000) begin
      cycle((written < 1000) && ($urandom_range(1, 0) == 1), $urandom_range(1, 0) == 1,
            $urandom_range(7, 0) != 0, pop_o, ra_o, hs_o, ov_o, od_o);
      if (hs_o) delivered++;
      cyc++;
    end
    n_cmp++;
    if (delivered != 1000 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_total: got %0d delivered left=%0d want 1000/0 (%0d cycles)", delivered, exp_q.size(), cyc);
    end
  endtask

  task automatic test_aclr();
    bit pop_o, hs_o, ov_o;
    int ra_o;
    logic [DW-1:0] od_o;
    do_reset();
    preload(6);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
    n_cmp++;
    if (Out_Valid !== 1'b1) begin
      n_err++;
      $display("FAIL aclr_setup: got V=%0b want 1", Out_Valid);
    end
    @(negedge clk);
    clk_en    = 1'b1;
    Out_Ready = 1'b1;
    aclr      = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (Out_Valid !== 1'b0 || R_Addr !== '0 || Pop !== 1'b0) begin
      n_err++;
      $display("FAIL aclr_async: got V=%0b R=%0d P=%0b want 0/0/0", Out_Valid, R_Addr, Pop);
    end
    @(posedge clk);
    @(posedge clk);
    #1 aclr = 1'b0;
    n_cmp++;
    if (Out_Data !== '0 || Out_Valid !== 1'b0) begin
      n_err++;
      $display("FAIL aclr_release: got D=%h V=%0b want 0/0", Out_Data, Out_Valid);
    end
`ifdef RD_LEVEL_EN
    n_cmp++;
    if (Level !== '0 || Almost_Empty !== 1'b1) begin
      n_err++;
      $display("FAIL aclr_level: got %0d/%0b want 0/1", Level, Almost_Empty);
    end
`endif
    preload(3);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, pop_o, ra_o, hs_o, ov_o, od_o);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL aclr_restart: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    aclr      = 1'b1;
    clk_en    = 1'b0;
    Out_Ready = 1'b0;
    n_cmp     = 0;
    n_err     = 0;
    model_reset();
    test_reset();
    test_fill5();
    test_wrap();
    test_backpressure();
    test_clk_en();
    test_random();
    test_aclr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/round_buffer_reader.md
Name: round_buffer_reader

Overview:
Read-side controller for the circular sample buffer in the convolution engine. It owns the read pointer and derives empty and level from the writer's address and the wrap flag. It issues pops to the buffer RAM, which has a registered read with 1-cycle latency. It presents the popped words to the downstream MAC stage over a valid/ready stream, sustaining 1 word/cycle.

Parameters:
- BufferWidth, 4, address width of R_Addr/W_Addr
- BufferSize, 16, number of RAM entries; any value 2..2^BufferWidth, need not be a power of 2
- DataWidth, 16, sample width

Ports:
- clk  in  1  system clock
- aclr  in  1  reset, asynchronous, active-high
- clk_en  in  1  global enable; when low, all state holds and Pop=0
- W_Addr  in  BufferWidth  writer's next write address
- Round  in  1  wrap flag from the write-side tracker: 1 = writer has wrapped and reader has not
- R_Addr  out  BufferWidth  read address to RAM and tracker
- Pop  out  1  read strobe to RAM and tracker
- Mem_RData  in  DataWidth  RAM read data, valid the cycle after Pop
- Empty  out  1  buffer holds no unpopped words
- Out_Data  out  DataWidth  stream data
- Out_Valid  out  1  stream valid
- Out_Ready  in  1  downstream accept

Behaviour:
- Reset values: R_Addr=0, Pop=0, Out_Valid=0, Out_Data=0, in-flight flag=0, skid empty.
- Empty and full are combinational from Round, W_Addr and R_Addr:
  - Empty = !Round && (W_Addr==R_Addr)
  - Full = Round && (W_Addr==R_Addr); internal only
- Level:
  - Round=0: W_Addr-R_Addr
  - Round=1: BufferSize-R_Addr+W_Addr
  - Width BufferWidth+1, no overflow.
- Pop is combinational:
  - Pop = clk_en && !Empty && (slots<2 || (slots==2 && Out_Valid && Out_Ready))
  - slots = in-flight + skid entries held.
- R_Addr update on every edge where Pop=1:
  - R_Addr = (R_Addr==BufferSize-1) ? 0 : R_Addr+1.
  - Wrapping from BufferSize-1 clears Round in the tracker on the same edge.
- Read latency: Pop at cycle N. Mem_RData is captured at the end of cycle N+1. Out_Valid is high in cycle N+2 at the earliest.
- Skid buffer, 2 entries (main, spare), in-order:
  - Returning data goes to main if main is empty or being consumed, else to spare.
  - Spare shifts to main on consume.
  - Out_Data and Out_Valid come from main.
- Stream rules:
  - Out_Data is stable while Out_Valid && !Out_Ready.
  - Out_Valid never drops without a handshake.
  - No word is lost or duplicated.
- Throughput: with Out_Ready held high and a non-empty buffer, one word per cycle in steady state.
- clk_en=0: no pointer, skid or in-flight changes. A capture already in flight completes only when clk_en returns. The RAM is gated by the same clk_en, so Mem_RData holds.
- Simultaneous write and pop are legal. Empty re-evaluates each cycle from live W_Addr and Round.
- Reset mid-operation: all in-flight and skid data is discarded. Writer and tracker share aclr, so both sides restart at address 0.

Optional Feature:
- Macro RD_LEVEL_EN.
- When defined, adds:
  - Level output port, BufferWidth+1 bits, registered, updated each enabled edge from the formula above.
  - Almost_Empty output port, registered, = (Level <= AlmostEmptyThr).
  - Parameter AlmostEmptyThr, default 2.
  - Both outputs reset to Level=0, Almost_Empty=1.
- When undefined: neither port exists and there is no level logic. Core behaviour is identical.

Decomposition:
- Shared package/include holds the BufferWidth, BufferSize and DataWidth defaults, plus a level-width constant BufferWidth+1.
- One sub-module, round_rd_skid: 2-entry valid/ready skid buffer.
  - Inputs: push data/valid.
  - Outputs: Out_Data, Out_Valid, occupancy count.
- The top level keeps the pointer, empty and Pop logic.

Test Plan:
- Reset, then W_Addr=0, Round=0 → Empty=1, Pop never asserts, Out_Valid=0 and R_Addr=0 for 20 cycles.
- Writer fills 5 words (W_Addr=5), Out_Ready=1 → Pop on 5 consecutive cycles. Out_Data = words 0..4 on consecutive cycles, first valid 2 cycles after first Pop. Empty=1 after R_Addr=5.
- BufferSize=16, R_Addr=14, W_Addr=2, Round=1 → pops at 14, 15, then R_Addr wraps to 0. Tracker clears Round. Level goes 4→0, reaching Empty at R_Addr=2.
- Out_Ready=0 with 8 words buffered → exactly 2 pops issued, then Pop=0. Out_Data holds word 0. Releasing Out_Ready delivers words 0..7 in order with no gaps after refill.
- Random Out_Ready (50%) and random writes over 1000 words → scoreboard shows in-order, no loss or duplication. R_Addr never passes W_Addr when Round=0.
- aclr pulse mid-stream with the skid full → within the same cycle Out_Valid=0, R_Addr=0, Pop=0. After release, with RD_LEVEL_EN defined: Level=0 and Almost_Empty=1.
